addsub_share_sched: RTL and testbench

- Schedules one shared RC_ADD_SUB_32 instance between two requesters, e.g. the ALU and the address/PC-update path.
- Round-robin arbitration between the two requesters.
- Executes 32-bit ops in one adder pass.
- Executes 64-bit ops as a multi-pass sequence (low pass, high pass, optional carry-fix pass). The adder has no separate carry-in; its carry-in is tied to SnA, so the fix pass is needed.

---
 rtl/addsub_share_sched.sv | 214 +++++++++++++++++++++
 tb/tb_addsub_share_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_sched.sv
// addsub_share_sched: shares one 32-bit ripple add/sub unit between two
// requesters with round-robin arbitration. Narrow ops take one adder pass;
// wide (64-bit) ops take a low pass, a high pass and, when the low-half carry
// disagrees with the adder's SnA-tied carry-in, a carry-fix pass.
// Optional build macro: ADDSUB_SCHED_OVF_EN adds the rsp_ovf signed-overflow output.

// Shared adder: carry-in is tied to sna, subtract inverts b.
module rc_add_sub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sna,
    output logic [W-1:0] y,
    output logic         co
);
    logic [W:0] sum;

    // One combinational ripple pass: a + (b ^ sna) + sna.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b ^ {W{sna}}} + {{W{1'b0}}, sna};
        y   = sum[W-1:0];
        co  = sum[W];
    end
endmodule

module addsub_share_sched #(
    parameter int NREQ   = 2,
    parameter int HALF_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*2*HALF_W-1:0] req_a,
    input  logic [NREQ*2*HALF_W-1:0] req_b,
    input  logic [NREQ-1:0]          req_sna,
    input  logic [NREQ-1:0]          req_wide,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic [2*HALF_W-1:0]      rsp_y,
    output logic                     rsp_co
`ifdef ADDSUB_SCHED_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);
    localparam int FW = 2 * HALF_W;

    typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

    state_t            state;
    logic              ptr;
    logic              grant;
    logic              take;
    logic [FW-1:0]     a_q;
    logic [FW-1:0]     b_q;
    logic              sna_q;
    logic              wide_q;
    logic              id_q;
    logic [HALF_W-1:0] lo_q;
    logic [HALF_W-1:0] hi_q;
    logic              c0_q;
    logic              c2_q;
    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic              add_sna;
    logic [HALF_W-1:0] add_y;
    logic              add_co;
    logic              fix_needed;

`ifdef ADDSUB_SCHED_OVF_EN
    function automatic logic ovf_of(input logic am, input logic bm, input logic ym, input logic sna);
        if (sna)
            return (am != bm) && (ym != am);
        else
            return (am == bm) && (ym != am);
    endfunction
`endif

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11)
            grant = ~ptr;
    end

    // Accept only from IDLE and never while reset is asserted.
    always_comb begin
        req_ready        = '0;
        req_ready[grant] = (state == IDLE) & req_valid[grant] & ~rst;
    end

    assign take = |(req_valid & req_ready);

    // The high half must absorb the low-half carry, which the SnA-tied carry-in did not supply.
    assign fix_needed = sna_q ? ~c0_q : c0_q;

    // Steer the shared adder per pass; idle states drive zeros.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sna = 1'b0;
        case (state)
            LO: begin
                add_a   = a_q[HALF_W-1:0];
                add_b   = b_q[HALF_W-1:0];
                add_sna = sna_q;
            end
            HI: begin
                add_a   = a_q[FW-1:HALF_W];
                add_b   = b_q[FW-1:HALF_W];
                add_sna = sna_q;
            end
            FIX: begin
                add_a   = hi_q;
                add_b   = {{(HALF_W-1){1'b0}}, 1'b1};
                add_sna = sna_q;
            end
            default: ;
        endcase
    end

    rc_add_sub #(.W(HALF_W)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sna (add_sna),
        .y   (add_y),
        .co  (add_co)
    );

    // Scheduler FSM: one adder pass per cycle, results and response registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_co    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sna_q     <= 1'b0;
            wide_q    <= 1'b0;
            id_q      <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            c0_q      <= 1'b0;
            c2_q      <= 1'b0;
`ifdef ADDSUB_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        a_q    <= grant ? req_a[2*FW-1:FW] : req_a[FW-1:0];
                        b_q    <= grant ? req_b[2*FW-1:FW] : req_b[FW-1:0];
                        sna_q  <= req_sna[grant];
                        wide_q <= req_wide[grant];
                        id_q   <= grant;
                        ptr    <= grant;
                        state  <= LO;
                    end
                end
                LO: begin
                    lo_q <= add_y;
                    c0_q <= add_co;
                    if (wide_q) begin
                        state <= HI;
                    end else begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_y     <= {{HALF_W{1'b0}}, add_y};
                        rsp_co    <= add_co;
`ifdef ADDSUB_SCHED_OVF_EN
                        rsp_ovf   <= ovf_of(a_q[HALF_W-1], b_q[HALF_W-1], add_y[HALF_W-1], sna_q);
`endif
                    end
                end
                HI: begin
                    hi_q <= add_y;
                    c2_q <= add_co;
                    if (fix_needed) begin
                        state <= FIX;
                    end else begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_y     <= {add_y, lo_q};
                        rsp_co    <= add_co;
`ifdef ADDSUB_SCHED_OVF_EN
                        rsp_ovf   <= ovf_of(a_q[FW-1], b_q[FW-1], add_y[HALF_W-1], sna_q);
`endif
                    end
                end
                FIX: begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_y     <= {add_y, lo_q};
                    rsp_co    <= sna_q ? (c2_q & add_co) : (c2_q | add_co);
`ifdef ADDSUB_SCHED_OVF_EN
                    rsp_ovf   <= ovf_of(a_q[FW-1], b_q[FW-1], add_y[HALF_W-1], sna_q);
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_share_sched.sv
// tb_addsub_share_sched: directed vectors with hand-computed results for the
// shared add/sub scheduler. Overflow checks compile in with ADDSUB_SCHED_OVF_EN.
module tb_addsub_share_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [1:0]   req_sna = '0;
    logic [1:0]   req_wide = '0;
    logic         rsp_valid;
    logic         rsp_id;
    logic [63:0]  rsp_y;
    logic         rsp_co;
    logic         rsp_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    addsub_share_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sna   (req_sna),
        .req_wide  (req_wide),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_co    (rsp_co)
`ifdef ADDSUB_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

`ifndef ADDSUB_SCHED_OVF_EN
    assign rsp_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "[TB] watchdog");
    end

    // Issue one op from requester id and report cycles from handshake edge to response (-1 = none).
    task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b,
                          input logic sna, input logic wide, output int lat,
                          output logic [63:0] y, output logic co, output logic rid, output logic ovf);
        bit got;
        lat = -1; y = '0; co = 1'b0; rid = 1'b0; ovf = 1'b0;
        @(negedge clk);
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        req_sna[id]  = sna;
        req_wide[id] = wide;
        req_valid[id] = 1'b1;
        #1;
        got = 0;
        for (int w = 0; w < 20 && !got; w++) begin
            if (req_ready[id]) got = 1;
            else @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k == 1) req_valid[id] = 1'b0;
                if (rsp_valid) begin
                    lat = k; y = rsp_y; co = rsp_co; rid = rsp_id; ovf = rsp_ovf;
                    break;
                end
            end
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b00) $display("[TB] FAIL reset_ready: got %b want 00", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_y !== 64'h0) $display("[TB] FAIL reset_y: got %h want 0", rsp_y); else n_pass++;
        n_checks++; if (rsp_co !== 1'b0 || rsp_id !== 1'b0) $display("[TB] FAIL reset_co_id: got %b%b want 00", rsp_co, rsp_id); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("[TB] FAIL reset_first_grant: got %b want 01", req_ready); else n_pass++;
        req_valid = 2'b00;
    endtask

    task automatic test_narrow();
        int lat; logic [63:0] y; logic co, rid, ovf;
        run_op(0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (lat !== 2) $display("[TB] FAIL narrow_add_lat: got %0d want 2", lat); else n_pass++;
        n_checks++; if (rid !== 1'b0) $display("[TB] FAIL narrow_add_id: got %b want 0", rid); else n_pass++;
        n_checks++; if (y !== 64'h0) $display("[TB] FAIL narrow_add_y: got %h want 0", y); else n_pass++;
        n_checks++; if (co !== 1'b1) $display("[TB] FAIL narrow_add_co: got %b want 1", co); else n_pass++;
        run_op(1, 64'h0, 64'h1, 1'b1, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h0000_0000_FFFF_FFFF || co !== 1'b0) $display("[TB] FAIL narrow_sub_wrap: got %h/%b want 00000000ffffffff/0", y, co); else n_pass++;
        run_op(0, 64'hDEAD_0000_0000_0005, 64'hBEEF_0000_0000_0003, 1'b1, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h2 || co !== 1'b1 || lat !== 2) $display("[TB] FAIL narrow_upper_ignored: got %h/%b/%0d want 2/1/2", y, co, lat); else n_pass++;
    endtask

    task automatic test_wide();
        int lat; logic [63:0] y; logic co, rid, ovf;
        run_op(1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1, lat, y, co, rid, ovf);
        n_checks++; if (lat !== 4) $display("[TB] FAIL wide_add_fix_lat: got %0d want 4", lat); else n_pass++;
        n_checks++; if (rid !== 1'b1) $display("[TB] FAIL wide_add_fix_id: got %b want 1", rid); else n_pass++;
        n_checks++; if (y !== 64'h0000_0001_0000_0000) $display("[TB] FAIL wide_add_fix_y: got %h want 0000000100000000", y); else n_pass++;
        n_checks++; if (co !== 1'b0) $display("[TB] FAIL wide_add_fix_co: got %b want 0", co); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rsp_pulse: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_y !== 64'h0000_0001_0000_0000 || rsp_id !== 1'b1) $display("[TB] FAIL rsp_hold: got %h/%b want 0000000100000000/1", rsp_y, rsp_id); else n_pass++;
        run_op(0, 64'h0000_0002_0000_0005, 64'h0000_0001_0000_0003, 1'b0, 1'b1, lat, y, co, rid, ovf);
        n_checks++; if (lat !== 3) $display("[TB] FAIL wide_nofix_lat: got %0d want 3", lat); else n_pass++;
        n_checks++; if (y !== 64'h0000_0003_0000_0008 || co !== 1'b0) $display("[TB] FAIL wide_nofix_y: got %h/%b want 0000000300000008/0", y, co); else n_pass++;
        run_op(0, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 1'b1, lat, y, co, rid, ovf);
        n_checks++; if (lat !== 4) $display("[TB] FAIL wide_sub_fix_lat: got %0d want 4", lat); else n_pass++;
        n_checks++; if (y !== 64'h0000_0000_FFFF_FFFF || co !== 1'b1) $display("[TB] FAIL wide_sub_fix_y: got %h/%b want 00000000ffffffff/1", y, co); else n_pass++;
        run_op(1, 64'h0, 64'h1, 1'b1, 1'b1, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFFF || co !== 1'b0) $display("[TB] FAIL wide_sub_under: got %h/%b want ffffffffffffffff/0", y, co); else n_pass++;
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h0 || co !== 1'b1 || lat !== 4) $display("[TB] FAIL wide_add_wrap: got %h/%b/%0d want 0/1/4", y, co, lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int grants[3];
        int rids[3];
        int rcyc[3];
        logic [63:0] ys[3];
        int ng, nr;
        bit onehot_bad;
        ng = 0; nr = 0; onehot_bad = 0;
        for (int i = 0; i < 3; i++) begin grants[i] = -1; rids[i] = -1; rcyc[i] = -100; ys[i] = '0; end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_a = {64'd10, 64'd1};
        req_b = {64'd4, 64'd2};
        req_sna = 2'b10;
        req_wide = 2'b00;
        req_valid = 2'b11;
        #1;
        for (int j = 0; j < 12; j++) begin
            if (req_ready == 2'b11) onehot_bad = 1;
            if (req_ready != 2'b00 && ng < 3) begin grants[ng] = int'(req_ready[1]); ng++; end
            if (rsp_valid && nr < 3) begin rids[nr] = int'(rsp_id); rcyc[nr] = j; ys[nr] = rsp_y; nr++; end
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        n_checks++; if (grants[0] !== 0 || grants[1] !== 1 || grants[2] !== 0) $display("[TB] FAIL b2b_grants: got %0d,%0d,%0d want 0,1,0", grants[0], grants[1], grants[2]); else n_pass++;
        n_checks++; if (onehot_bad !== 1'b0) $display("[TB] FAIL b2b_onehot: got both ready want one-hot"); else n_pass++;
        n_checks++; if (rids[0] !== 0 || rids[1] !== 1 || rids[2] !== 0) $display("[TB] FAIL b2b_rsp_id: got %0d,%0d,%0d want 0,1,0", rids[0], rids[1], rids[2]); else n_pass++;
        n_checks++; if (rcyc[0] !== 2 || rcyc[1] - rcyc[0] !== 3 || rcyc[2] - rcyc[1] !== 3) $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d want 2,5,8", rcyc[0], rcyc[1], rcyc[2]); else n_pass++;
        n_checks++; if (ys[0] !== 64'd3 || ys[1] !== 64'd6 || ys[2] !== 64'd3) $display("[TB] FAIL b2b_y: got %0d,%0d,%0d want 3,6,3", ys[0], ys[1], ys[2]); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int lat; logic [63:0] y; logic co, rid, ovf;
        bit saw_valid;
        saw_valid = 0;
        run_op(1, 64'hFFFF_FFFF, 64'h2, 1'b0, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h1 || co !== 1'b1 || rid !== 1'b1) $display("[TB] FAIL midop_setup: got %h/%b/%b want 1/1/1", y, co, rid); else n_pass++;
        @(negedge clk);
        req_a[63:0] = 64'h0000_0000_FFFF_FFFF;
        req_b[63:0] = 64'h1;
        req_sna[0]  = 1'b0;
        req_wide[0] = 1'b1;
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1;
        end
        #1;
        n_checks++; if (rsp_y !== 64'h0 || rsp_co !== 1'b0 || rsp_id !== 1'b0) $display("[TB] FAIL midop_outputs: got %h/%b/%b want 0/0/0", rsp_y, rsp_co, rsp_id); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("[TB] FAIL midop_ready_in_reset: got %b want 00", req_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("[TB] FAIL midop_regrant: got %b want 01", req_ready); else n_pass++;
        req_valid = 2'b00;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1;
        end
        n_checks++; if (saw_valid !== 1'b0) $display("[TB] FAIL midop_no_rsp: got response want none"); else n_pass++;
    endtask

`ifdef ADDSUB_SCHED_OVF_EN
    task automatic test_overflow();
        int lat; logic [63:0] y; logic co, rid, ovf;
        run_op(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h8000_0000 || ovf !== 1'b1 || co !== 1'b0) $display("[TB] FAIL ovf_add: got %h/%b/%b want 80000000/1/0", y, ovf, co); else n_pass++;
        run_op(1, 64'h8000_0000, 64'h1, 1'b1, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h7FFF_FFFF || ovf !== 1'b1 || co !== 1'b1) $display("[TB] FAIL ovf_sub: got %h/%b/%b want 7fffffff/1/1", y, ovf, co); else n_pass++;
        run_op(0, 64'h1, 64'h1, 1'b0, 1'b0, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h2 || ovf !== 1'b0) $display("[TB] FAIL ovf_none: got %h/%b want 2/0", y, ovf); else n_pass++;
        run_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, lat, y, co, rid, ovf);
        n_checks++; if (y !== 64'h8000_0000_0000_0000 || ovf !== 1'b1 || co !== 1'b0) $display("[TB] FAIL ovf_wide: got %h/%b/%b want 8000000000000000/1/0", y, ovf, co); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_narrow();
        test_wide();
        test_back_to_back();
        test_reset_midop();
`ifdef ADDSUB_SCHED_OVF_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
